// File: rtl/alu_writeback_pkg.sv
// Shared encodings for the ALU write-back path: write-back modes, address
// post-adjust codes and write-back FSM state encodings.
package alu_writeback_pkg;

    localparam int ALU_WB_DATA_W = 16;
    localparam int ALU_WB_REG_AW = 4;
    localparam int ALU_WB_FLAG_W = 4;

    typedef enum logic [1:0] {
        WB_MODE_NONE = 2'b00,
        WB_MODE_FULL = 2'b01,
        WB_MODE_HIGH = 2'b10,
        WB_MODE_LOW  = 2'b11
    } wb_mode_e;

    typedef enum logic [1:0] {
        LDSINCF_NONE = 2'b00,
        LDSINCF_INC1 = 2'b01,
        LDSINCF_INC2 = 2'b10,
        LDSINCF_DEC2 = 2'b11
    } ldsincf_e;

    typedef enum logic [1:0] {
        WBSTATE_IDLE = 2'b00,
        WBSTATE_RES  = 2'b01,
        WBSTATE_INC  = 2'b10
    } wb_state_e;

endpackage

// File: rtl/alu_writeback_merge.sv
// Byte-lane merge for half-register writes and post-adjust value generation
// for the address register. Purely combinational.
module alu_writeback_merge
    import alu_writeback_pkg::*;
#(
    parameter int DATA_W = ALU_WB_DATA_W
) (
    input  logic [DATA_W-1:0] result,
    input  logic [DATA_W-1:0] old,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] inc_base,
    input  logic [1:0]        ldsincf,
    output logic [DATA_W-1:0] merged,
    output logic [DATA_W-1:0] inc_sum
);

    logic [DATA_W-1:0] delta;

    // Lane merge: HIGH places the result's low byte in the upper lane.
    always_comb begin
        merged = result;
        case (mode)
            WB_MODE_HIGH: merged = {result[7:0], old[DATA_W-9:0]};
            WB_MODE_LOW:  merged = {old[DATA_W-1:8], result[7:0]};
            default:      merged = result;
        endcase
    end

    // Post-adjust delta; -2 is the two's-complement of 2 so the add wraps.
    always_comb begin
        delta = '0;
        case (ldsincf)
            LDSINCF_INC1: delta = DATA_W'(1);
            LDSINCF_INC2: delta = DATA_W'(2);
            LDSINCF_DEC2: delta = ~DATA_W'(1);
            default:      delta = '0;
        endcase
    end

    assign inc_sum = inc_base + delta;

endmodule

// File: rtl/alu_writeback.sv
// ALU result write-back: captures an ALU result with its write-back fields,
// updates the flag register and issues up to two register-file writes (the
// result, then an optional address post-adjust) through one shared port.
//
// state        | meaning
// -------------+----------------------------------------------------------
// WBSTATE_IDLE | ready for a new ALU result
// WBSTATE_RES  | result write presented, waiting for arbiter grant
// WBSTATE_INC  | address post-adjust write presented, waiting for grant
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int DATA_W = ALU_WB_DATA_W,
    parameter int REG_AW = ALU_WB_REG_AW,
    parameter int FLAG_W = ALU_WB_FLAG_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic              flags_en,
    input  logic [1:0]        wb_mode,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_old,
    input  logic [1:0]        ldsincf,
    input  logic [REG_AW-1:0] inc_reg,
    input  logic [DATA_W-1:0] inc_base,
    output logic              reg_we,
    output logic [REG_AW-1:0] reg_waddr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic              reg_wready,
    output logic [FLAG_W-1:0] flags_out
);

    wb_state_e         state;
    wb_state_e         state_nxt;
    logic              accept;

    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] inc_sum;

    // Second write is captured already resolved, so WB_RES only has to
    // copy it onto the port when the result write is granted.
    logic              inc_pend_q;
    logic [REG_AW-1:0] inc_reg_q;
    logic [DATA_W-1:0] inc_data_q;

    logic              has_res;
    logic              has_inc;

    alu_writeback_merge #(
        .DATA_W (DATA_W)
    ) u_merge (
        .result   (alu_result),
        .old      (wb_old),
        .mode     (wb_mode),
        .inc_base (inc_base),
        .ldsincf  (ldsincf),
        .merged   (merged),
        .inc_sum  (inc_sum)
    );

    assign has_res   = (wb_mode != WB_MODE_NONE);
    assign has_inc   = (ldsincf != LDSINCF_NONE);
    assign alu_ready = (state == WBSTATE_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= WBSTATE_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the accept strobe only exists in IDLE.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            WBSTATE_IDLE: begin
                if (alu_valid) begin
                    accept = 1'b1;
                    if (has_res) begin
                        state_nxt = WBSTATE_RES;
                    end else if (has_inc) begin
                        state_nxt = WBSTATE_INC;
                    end
                end
            end
            WBSTATE_RES: begin
                if (reg_wready) begin
                    state_nxt = inc_pend_q ? WBSTATE_INC : WBSTATE_IDLE;
                end
            end
            WBSTATE_INC: begin
                if (reg_wready) begin
                    state_nxt = WBSTATE_IDLE;
                end
            end
            default: state_nxt = WBSTATE_IDLE;
        endcase
    end

    // Write port, flags and pending post-adjust; port holds until granted.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            reg_we     <= 1'b0;
            reg_waddr  <= '0;
            reg_wdata  <= '0;
            flags_out  <= '0;
            inc_pend_q <= 1'b0;
            inc_reg_q  <= '0;
            inc_data_q <= '0;
        end else begin
            case (state)
                WBSTATE_IDLE: begin
                    if (accept) begin
                        if (flags_en) begin
                            flags_out <= alu_flags;
                        end
                        inc_reg_q  <= inc_reg;
                        inc_data_q <= inc_sum;
                        // A post-adjust of the destination itself is dropped.
                        inc_pend_q <= has_res && has_inc && (inc_reg != wb_dest);
                        if (has_res) begin
                            reg_we    <= 1'b1;
                            reg_waddr <= wb_dest;
                            reg_wdata <= merged;
                        end else if (has_inc) begin
                            reg_we    <= 1'b1;
                            reg_waddr <= inc_reg;
                            reg_wdata <= inc_sum;
                        end
                    end
                end
                WBSTATE_RES: begin
                    if (reg_wready) begin
                        inc_pend_q <= 1'b0;
                        if (inc_pend_q) begin
                            reg_waddr <= inc_reg_q;
                            reg_wdata <= inc_data_q;
                        end else begin
                            reg_we <= 1'b0;
                        end
                    end
                end
                WBSTATE_INC: begin
                    if (reg_wready) begin
                        reg_we <= 1'b0;
                    end
                end
                default: reg_we <= 1'b0;
            endcase
        end
    end

endmodule
